// File: rtl/data_mem_responder_if.sv
// Handshake bundle between the processor MEM stage (master) and the data
// memory responder (slave).
interface data_mem_responder_if;
   logic        MemReq;
   logic        MemWrite;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        MemReady;
   logic        MemStall;
   logic        Error;

   modport master (
      output MemReq, MemWrite, Addr, WriteData,
      input  ReadData, MemReady, MemStall, Error
   );

   modport slave (
      input  MemReq, MemWrite, Addr, WriteData,
      output ReadData, MemReady, MemStall, Error
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: one load/store at a time, optional wait states
// (present only when DMEM_WAIT_STATES_EN is defined), one-cycle MemReady strobe.
module data_mem_responder #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned DEPTH_LOG2  = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

`ifdef DMEM_WAIT_STATES_EN
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`else
   typedef enum logic [0:0] {IDLE, RESP} state_t;
`endif

   state_t                state_q, state_d;
   logic                  accept;
   logic                  resp_entry;

   logic                  cap_write;
   logic [31:0]           cap_addr;
   logic [31:0]           cap_data;

   logic                  op_write;
   logic [31:0]           op_addr;
   logic [31:0]           op_data;
   logic                  op_misaligned;
   logic [DEPTH_LOG2-1:0] op_idx;
   logic                  mem_we;

   logic [31:0]           rdata_q;
   logic                  err_q;
   logic [31:0]           mem [DEPTH];

`ifdef DMEM_WAIT_STATES_EN
   localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
   logic [3:0]            cnt_q, cnt_d;
`else
   logic                  unused_wait_cycles;
   assign unused_wait_cycles = ^WAIT_CYCLES;
`endif

   // A request that goes straight to RESP (no wait states) is served from the
   // live bus on its acceptance edge; later ones use the captured copy.
   assign op_write      = (state_q == IDLE) ? bus.MemWrite  : cap_write;
   assign op_addr       = (state_q == IDLE) ? bus.Addr      : cap_addr;
   assign op_data       = (state_q == IDLE) ? bus.WriteData : cap_data;
   assign op_misaligned = |op_addr[1:0];
   assign op_idx        = op_addr[DEPTH_LOG2+1:2];

   // Upper address bits alias onto the array and are deliberately ignored.
   logic unused_addr_hi;
   assign unused_addr_hi = ^op_addr[31:DEPTH_LOG2+2];

   // Gating with reset keeps a store from landing while the block is held in reset.
   assign mem_we = reset & resp_entry & op_write & ~op_misaligned;

   // NOTE: every signal driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      resp_entry = 1'b0;
`ifdef DMEM_WAIT_STATES_EN
      cnt_d      = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.MemReq) begin
               accept = 1'b1;
`ifdef DMEM_WAIT_STATES_EN
               if (WAIT_CYCLES == 0) begin
                  state_d    = RESP;
                  resp_entry = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
`else
               state_d    = RESP;
               resp_entry = 1'b1;
`endif
            end
         end
`ifdef DMEM_WAIT_STATES_EN
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = RESP;
               resp_entry = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_data  <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
`ifdef DMEM_WAIT_STATES_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
`ifdef DMEM_WAIT_STATES_EN
         cnt_q   <= cnt_d;
`endif
         if (accept) begin
            cap_write <= bus.MemWrite;
            cap_addr  <= bus.Addr;
            cap_data  <= bus.WriteData;
         end
         if (resp_entry) begin
            err_q <= op_misaligned;
            if (!op_write) begin
               rdata_q <= op_misaligned ? '0 : mem[op_idx];
            end
         end
      end
   end

   // NOTE: the storage array has no reset; contents survive reset and the
   // array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[op_idx] <= op_data;
      end
   end

   assign bus.ReadData = rdata_q;
   assign bus.MemReady = (state_q == RESP);
   assign bus.Error    = (state_q == RESP) & err_q;
`ifdef DMEM_WAIT_STATES_EN
   assign bus.MemStall = reset & (((state_q == IDLE) & bus.MemReq) | (state_q == WAIT));
`else
   assign bus.MemStall = reset & (state_q == IDLE) & bus.MemReq;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: timeline-based reference model,
// per-cycle compare, directed scenarios with literal expectations, random traffic.
module tb_data_mem_responder;
   localparam int TB_WAIT = 2;
   localparam int DL      = 6;
`ifdef DMEM_WAIT_STATES_EN
   localparam int EFF_W = TB_WAIT;
`else
   localparam int EFF_W = 0;
`endif
   localparam int P = EFF_W + 2;

   logic clk;
   logic rst_n;
   data_mem_responder_if bus();

   data_mem_responder #(.WAIT_CYCLES(TB_WAIT), .DEPTH_LOG2(DL)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a request accepted at edge e completes at edge e+EFF_W,
   // and the block can accept again two edges after completion.
   logic [31:0] m_mem [1<<DL];
   int          cyc         = 0;
   int          m_next_free = 0;
   int          m_resp_edge = -100;
   bit          m_pending   = 1'b0;
   bit          m_ready     = 1'b0;
   bit          m_err       = 1'b0;
   logic [31:0] m_rd        = '0;
   bit          p_write;
   logic [31:0] p_addr;
   logic [31:0] p_data;

   always @(posedge clk) begin
      cyc++;
      m_ready = 1'b0;
      m_err   = 1'b0;
      if (!rst_n) begin
         m_pending   = 1'b0;
         m_rd        = '0;
         m_next_free = cyc + 1;
      end else begin
         if (!m_pending && cyc >= m_next_free && bus.MemReq === 1'b1) begin
            p_write     = bus.MemWrite;
            p_addr      = bus.Addr;
            p_data      = bus.WriteData;
            m_pending   = 1'b1;
            m_resp_edge = cyc + EFF_W;
         end
         if (m_pending && cyc == m_resp_edge) begin
            if (p_addr[1:0] != 2'b00) begin
               m_err = 1'b1;
               if (!p_write) m_rd = '0;
            end else if (p_write) begin
               m_mem[p_addr[DL+1:2]] = p_data;
            end else begin
               m_rd = m_mem[p_addr[DL+1:2]];
            end
            m_ready     = 1'b1;
            m_pending   = 1'b0;
            m_next_free = cyc + 2;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst ReadData", bus.ReadData, 32'h0);
         check("rst MemReady", 32'(bus.MemReady), 32'h0);
         check("rst Error",    32'(bus.Error),    32'h0);
         check("rst MemStall", 32'(bus.MemStall), 32'h0);
      end else begin
         check("ReadData", bus.ReadData, m_rd);
         check("MemReady", 32'(bus.MemReady), 32'(m_ready));
         check("Error",    32'(bus.Error),    32'(m_err));
         check("MemStall", 32'(bus.MemStall), 32'(m_pending || (!m_ready && bus.MemReq)));
      end
   end

   // One access on an idle bus; inputs are scrambled right after acceptance.
   task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output bit err, output int lat,
                         output int stall_cnt, output bit stall_rdy, output bit got);
      @(posedge clk); #1;
      bus.MemReq    = 1'b1;
      bus.MemWrite  = wr;
      bus.Addr      = addr;
      bus.WriteData = wdata;
      got = 1'b0; lat = 0; stall_cnt = 0; stall_rdy = 1'b0; rdata = '0; err = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.MemStall) stall_cnt++;
         if (bus.MemReady) begin
            got       = 1'b1;
            lat       = i;
            rdata     = bus.ReadData;
            err       = bus.Error;
            stall_rdy = bus.MemStall;
         end
         @(posedge clk); #1;
         if (i == 0) begin
            bus.MemReq    = 1'b0;
            bus.MemWrite  = 1'($urandom_range(0, 1));
            bus.Addr      = $urandom;
            bus.WriteData = $urandom;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      bit          er, gt, srdy;
      int          lat, scnt, rdy_seen, n_rdy;
      logic [31:0] b2b_addr [4];
      logic [31:0] b2b_exp  [4];
      logic [31:0] b2b_got  [4];
      int          b2b_cyc  [4];
      logic [31:0] a;

      // Reset with a request held on the bus: stall must stay low.
      rst_n         = 1'b0;
      bus.MemReq    = 1'b1;
      bus.MemWrite  = 1'b1;
      bus.Addr      = 32'h0;
      bus.WriteData = 32'h1;
      @(negedge clk); @(negedge clk);
      check("reset ReadData", bus.ReadData, 32'h0);
      check("reset MemReady", 32'(bus.MemReady), 32'h0);
      check("reset Error",    32'(bus.Error),    32'h0);
      check("reset MemStall", 32'(bus.MemStall), 32'h0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.MemReq = 1'b0;
      repeat (EFF_W + 3) @(posedge clk);

      for (int i = 0; i < (1 << DL); i++)
         access(1'b1, 32'(i * 4), {16'hA5A5, 16'(i)}, rd, er, lat, scnt, srdy, gt);

      // Store then load.
      access(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, scnt, srdy, gt);
      check("st got",     32'(gt),  32'h1);
      check("st latency", 32'(lat), 32'(EFF_W + 1));
      check("st error",   32'(er),  32'h0);
      access(1'b0, 32'h10, 32'h0, rd, er, lat, scnt, srdy, gt);
      check("ld latency", 32'(lat), 32'(EFF_W + 1));
      check("ld data",    rd,       32'hDEADBEEF);
      check("ld error",   32'(er),  32'h0);
      check("model data", m_rd,     32'hDEADBEEF);

      // Stall profile of a single load.
      access(1'b0, 32'h10, 32'h0, rd, er, lat, scnt, srdy, gt);
      check("stall cycles",   32'(scnt), 32'(EFF_W + 1));
      check("stall at ready", 32'(srdy), 32'h0);

      // Misaligned store is dropped; misaligned load returns zero.
      access(1'b1, 32'h21, 32'h12345678, rd, er, lat, scnt, srdy, gt);
      check("mis st error", 32'(er), 32'h1);
      access(1'b0, 32'h20, 32'h0, rd, er, lat, scnt, srdy, gt);
      check("mis st kept", rd,      32'hA5A50008);
      check("mis ld ok",   32'(er), 32'h0);
      access(1'b0, 32'h22, 32'h0, rd, er, lat, scnt, srdy, gt);
      check("mis ld data",  rd,      32'h0);
      check("mis ld error", 32'(er), 32'h1);

      // Reset during the transaction aborts the store.
      @(posedge clk); #1;
      bus.MemReq    = 1'b1;
      bus.MemWrite  = 1'b1;
      bus.Addr      = 32'h08;
      bus.WriteData = 32'hAAAA5555;
      rdy_seen = 0;
      fork
         begin
            repeat (EFF_W + 6) begin
               @(negedge clk);
               if (bus.MemReady) rdy_seen++;
            end
         end
         begin
            for (int i = 0; i < EFF_W; i++) @(posedge clk);
            #1;
            rst_n      = 1'b0;
            bus.MemReq = 1'b0;
            @(posedge clk); @(posedge clk); #3;
            rst_n = 1'b1;
         end
      join
      check("abort no ready", 32'(rdy_seen), 32'h0);
      access(1'b0, 32'h08, 32'h0, rd, er, lat, scnt, srdy, gt);
      check("abort old data", rd, 32'hA5A50002);

      // Back-to-back loads with MemReq held high; high address bits alias.
      b2b_addr[0] = 32'h80000104; b2b_exp[0] = 32'hA5A50001;
      b2b_addr[1] = 32'h000000F0; b2b_exp[1] = 32'hA5A5003C;
      b2b_addr[2] = 32'h40000048; b2b_exp[2] = 32'hA5A50012;
      b2b_addr[3] = 32'h0000000C; b2b_exp[3] = 32'hA5A50003;
      @(posedge clk); #1;
      bus.MemReq   = 1'b1;
      bus.MemWrite = 1'b0;
      bus.Addr     = b2b_addr[0];
      n_rdy = 0;
      fork
         begin
            for (int t = 0; t < 4 * P + 6; t++) begin
               @(negedge clk);
               if (bus.MemReady && n_rdy < 4) begin
                  b2b_got[n_rdy] = bus.ReadData;
                  b2b_cyc[n_rdy] = t;
                  n_rdy++;
               end
            end
         end
         begin
            for (int j = 0; j < 4; j++) begin
               repeat ((j == 0) ? 1 : P) @(posedge clk);
               #1;
               if (j < 3) bus.Addr = b2b_addr[j + 1];
               else       bus.MemReq = 1'b0;
            end
         end
      join
      check("b2b count", 32'(n_rdy), 32'h4);
      for (int j = 0; j < n_rdy; j++) begin
         check("b2b data", b2b_got[j], b2b_exp[j]);
         if (j > 0) check("b2b period", 32'(b2b_cyc[j] - b2b_cyc[j - 1]), 32'(P));
      end

      // Random traffic with occasional asynchronous resets.
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 149) == 0) begin
            rst_n      = 1'b0;
            bus.MemReq = 1'($urandom_range(0, 1));
            @(posedge clk); @(posedge clk); #3;
            rst_n = 1'b1;
         end else begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            bus.MemReq    = 1'($urandom_range(0, 1));
            bus.MemWrite  = 1'($urandom_range(0, 1));
            bus.Addr      = a;
            bus.WriteData = $urandom;
         end
      end
      @(posedge clk); #1;
      bus.MemReq = 1'b0;
      repeat (EFF_W + 4) @(posedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
